// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction fetch stage.
//   Exception   : fault code carried with every fetched entry
//   IdSignals   : bundle handed to the decode stage
//   make_entry  : builds an IdSignals entry, linkAddress = pc + one word
package fetch_stage_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      EXCEPT_NONE             = 2'd0,
      EXCEPT_FETCH_FAULT      = 2'd1,
      EXCEPT_MISALIGNED_FETCH = 2'd2
   } Exception;

   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] programCounter;
      logic [31:0] linkAddress;
      Exception    exception;
   } IdSignals;

   typedef enum logic [1:0] {
      ST_START,
      ST_RUN,
      ST_HALTED
   } fetch_state_e;

   function automatic IdSignals make_entry(input logic [31:0] pc,
                                           input logic [31:0] instr,
                                           input Exception    exc);
      IdSignals e;
      e.instruction    = instr;
      e.programCounter = pc;
      e.linkAddress    = pc + 32'(WORD_BYTES);
      e.exception      = exc;
      return e;
   endfunction

endpackage

// File: rtl/fetch_stage_skid_buffer.sv
// One-entry holding register for a fetched entry that decode could not take.
//   clock, nReset : pipeline clock, async active-low reset
//   load          : capture data_in and mark full (wins over unload)
//   unload        : entry has been moved out, mark empty
//   flush         : drop the entry (wins over everything)
//   data_in/out   : entry in / held entry
//   full          : data_out holds a live entry
module fetch_skid_buffer
   import fetch_stage_pkg::*;
(
   input  logic     clock,
   input  logic     nReset,
   input  logic     load,
   input  logic     unload,
   input  logic     flush,
   input  IdSignals data_in,
   output IdSignals data_out,
   output logic     full
);

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         full     <= 1'b0;
         data_out <= '0;
      end else if (flush) begin
         full     <= 1'b0;
      end else if (load) begin
         full     <= 1'b1;
         data_out <= data_in;
      end else if (unload) begin
         full     <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding request at a
// time, buffers one entry under decode back-pressure and squashes in-flight
// fetches on redirects from execute.
//   clock, nReset          : pipeline clock, async active-low reset
//   imemReq/imemAddr       : request to instruction memory, held until imemAck
//   imemAck/Data/Error     : one-cycle response strobe with data / bus fault
//   redirectValid/Target   : redirect pulse and new PC from execute
//   idStall                : decode cannot accept this cycle
//   idValid/idSignals      : entry presented to decode
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_START  | first cycle after reset, launches the fetch at RESET_VECTOR
// ST_RUN    | streaming sequential fetches
// ST_HALTED | after a fetch fault or misaligned target, waits for a redirect
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        nReset,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemAck,
   input  logic [31:0] imemData,
   input  logic        imemError,
   input  logic        redirectValid,
   input  logic [31:0] redirectTarget,
   input  logic        idStall,
   output logic        idValid,
   output IdSignals    idSignals
);

   fetch_state_e state, state_n;

   logic        discard, discard_n;
   logic        pending_valid, pending_valid_n;
   logic [31:0] pending_target, pending_target_n;
   logic        req_n;
   logic [31:0] addr_n;
   logic        valid_n;
   IdSignals    out_n;

   logic        skid_load, skid_unload, skid_flush, skid_full, skid_full_n;
   IdSignals    skid_data;

   logic        ack_taken, waiting, entry_valid;
   IdSignals    entry;

   // Acks with no request out (e.g. stragglers after reset) are ignored.
   assign ack_taken = imemReq && imemAck;
   // A request still on the bus must keep its address until acked.
   assign waiting   = imemReq && !imemAck;

   fetch_skid_buffer u_skid (
      .clock    (clock),
      .nReset   (nReset),
      .load     (skid_load),
      .unload   (skid_unload),
      .flush    (skid_flush),
      .data_in  (entry),
      .data_out (skid_data),
      .full     (skid_full)
   );

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) state <= ST_START;
      else         state <= state_n;
   end

   always_comb begin
      state_n          = state;
      req_n            = imemReq;
      addr_n           = imemAddr;
      valid_n          = idValid;
      out_n            = idSignals;
      discard_n        = discard;
      pending_valid_n  = pending_valid;
      pending_target_n = pending_target;
      skid_load        = 1'b0;
      skid_unload      = 1'b0;
      skid_flush       = 1'b0;
      skid_full_n      = skid_full;
      entry_valid      = 1'b0;
      entry            = make_entry(imemAddr, imemData, EXCEPT_NONE);

      if (redirectValid) begin
         valid_n    = 1'b0;
         skid_flush = 1'b1;
         discard_n  = waiting;
         if (redirectTarget[1:0] != 2'b00) begin
            valid_n         = 1'b1;
            out_n           = make_entry(redirectTarget, '0, EXCEPT_MISALIGNED_FETCH);
            pending_valid_n = 1'b0;
            state_n         = ST_HALTED;
            if (!waiting) req_n = 1'b0;
         end else begin
            state_n = ST_RUN;
            if (waiting) begin
               pending_valid_n  = 1'b1;
               pending_target_n = redirectTarget;
            end else begin
               req_n           = 1'b1;
               addr_n          = redirectTarget;
               pending_valid_n = 1'b0;
            end
         end
      end else begin
         if (ack_taken && discard) begin
            discard_n       = 1'b0;
            pending_valid_n = 1'b0;
            req_n           = pending_valid;
            if (pending_valid) addr_n = pending_target;
         end else if (ack_taken) begin
            entry_valid = 1'b1;
            if (imemError) begin
               entry   = make_entry(imemAddr, '0, EXCEPT_FETCH_FAULT);
               state_n = ST_HALTED;
               req_n   = 1'b0;
            end else begin
               addr_n = imemAddr + 32'(WORD_BYTES);
            end
         end

         // A full skid always drains first so order is preserved; a new
         // entry arriving in the same cycle takes its place.
         if (skid_full) begin
            if (!idStall) begin
               valid_n = 1'b1;
               out_n   = skid_data;
               if (entry_valid) begin
                  skid_load = 1'b1;
               end else begin
                  skid_unload = 1'b1;
                  skid_full_n = 1'b0;
               end
            end
         end else if (entry_valid) begin
            if (!idValid || !idStall) begin
               valid_n = 1'b1;
               out_n   = entry;
            end else begin
               skid_load   = 1'b1;
               skid_full_n = 1'b1;
            end
         end else if (!idStall) begin
            valid_n = 1'b0;
         end

         case (state)
            ST_START: begin
               state_n = ST_RUN;
               req_n   = 1'b1;
               addr_n  = RESET_VECTOR;
            end
            ST_RUN: begin
               // Keep fetching only while there is somewhere to put the result.
               if (state_n == ST_RUN && !discard && !waiting) req_n = !skid_full_n;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         imemReq        <= 1'b0;
         imemAddr       <= RESET_VECTOR;
         idValid        <= 1'b0;
         idSignals      <= '0;
         discard        <= 1'b0;
         pending_valid  <= 1'b0;
         pending_target <= '0;
      end else begin
         imemReq        <= req_n;
         imemAddr       <= addr_n;
         idValid        <= valid_n;
         idSignals      <= out_n;
         discard        <= discard_n;
         pending_valid  <= pending_valid_n;
         pending_target <= pending_target_n;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic        clock = 1'b0;
   logic        nReset;
   logic        imemReq, imemAck, imemError, redirectValid, idStall, idValid;
   logic [31:0] imemAddr, imemData, redirectTarget;
   IdSignals    idSignals;

   logic        w_req, w_valid;
   logic [31:0] w_addr;
   IdSignals    w_sig;

   always #5 clock = ~clock;

   fetch_stage #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clock(clock), .nReset(nReset), .imemReq(imemReq), .imemAddr(imemAddr),
      .imemAck(imemAck), .imemData(imemData), .imemError(imemError),
      .redirectValid(redirectValid), .redirectTarget(redirectTarget),
      .idStall(idStall), .idValid(idValid), .idSignals(idSignals)
   );

   fetch_stage #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
      .clock(clock), .nReset(nReset), .imemReq(w_req), .imemAddr(w_addr),
      .imemAck(1'b1), .imemData(32'h0000_0013), .imemError(1'b0),
      .redirectValid(1'b0), .redirectTarget(32'h0),
      .idStall(1'b0), .idValid(w_valid), .idSignals(w_sig)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      Exception    exc;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          consumed = 0;

   // behavioural model: next live fetch PC, squash and halt bookkeeping
   logic [31:0] fetch_pc;
   logic        stale, halted_exp;
   // memory model
   logic        mem_busy, mem_hold, mem_rand;
   logic [31:0] mem_addr, err_addr;
   int          mem_cnt, mem_fixed, err_pct;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      q.delete();
      fetch_pc   = 32'h0;
      stale      = 1'b0;
      halted_exp = 1'b0;
      mem_busy   = 1'b0;
   endtask

   // One cycle: sample outputs, play memory, drive inputs, score consumption.
   task automatic tick(input logic stall, input logic rv, input logic [31:0] tgt);
      logic ack, err, live;
      exp_t e;
      ack = 1'b0;
      err = 1'b0;
      if (halted_exp && !stale) chk("halt_req", 32'(imemReq), 32'd0);
      if (mem_busy) begin
         chk("req_held", 32'(imemReq), 32'd1);
         chk("addr_stable", imemAddr, mem_addr);
      end else if (imemReq === 1'b1) begin
         mem_busy = 1'b1;
         mem_addr = imemAddr;
         mem_cnt  = mem_rand ? int'($urandom_range(0, 3)) : mem_fixed;
         if (!stale && !halted_exp) chk("req_addr", imemAddr, fetch_pc);
      end
      if (mem_busy && !mem_hold) begin
         if (mem_cnt == 0) begin
            ack      = 1'b1;
            mem_busy = 1'b0;
            err      = (mem_addr == err_addr) || (int'($urandom_range(0, 99)) < err_pct);
         end else begin
            mem_cnt--;
         end
      end
      imemAck        = ack;
      imemError      = ack && err;
      imemData       = (ack && !err) ? (mem_addr ^ 32'hA5A5_A5A5) : $urandom;
      idStall        = stall;
      redirectValid  = rv;
      redirectTarget = tgt;

      if (idValid === 1'b1 && !stall) begin
         checks++;
         assert (q.size() != 0) else begin
            errors++;
            $error("FAIL spurious_valid observed pc %h expected no entry", idSignals.programCounter);
         end
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("pc", idSignals.programCounter, e.pc);
            chk("instr", idSignals.instruction, e.instr);
            chk("exc", 32'(idSignals.exception), 32'(e.exc));
            if (e.exc == EXCEPT_NONE) chk("link", idSignals.linkAddress, e.pc + 32'd4);
            consumed++;
         end
      end

      live = ack && !rv && !stale && !halted_exp;
      if (ack && stale) stale = 1'b0;
      if (live) begin
         if (err) begin
            q.push_back('{pc: fetch_pc, instr: 32'h0, exc: EXCEPT_FETCH_FAULT});
            halted_exp = 1'b1;
         end else begin
            q.push_back('{pc: fetch_pc, instr: fetch_pc ^ 32'hA5A5_A5A5, exc: EXCEPT_NONE});
            fetch_pc = fetch_pc + 32'd4;
         end
      end
      if (rv) begin
         q.delete();
         if (imemReq === 1'b1 && !ack) stale = 1'b1;
         if (tgt[1:0] != 2'b00) begin
            q.push_back('{pc: tgt, instr: 32'h0, exc: EXCEPT_MISALIGNED_FETCH});
            halted_exp = 1'b1;
         end else begin
            halted_exp = 1'b0;
            fetch_pc   = tgt;
         end
      end
      @(negedge clock);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] tgt;
      int          n;
      nReset = 1'b0; imemAck = 1'b0; imemData = '0; imemError = 1'b0;
      redirectValid = 1'b0; redirectTarget = '0; idStall = 1'b0;
      mem_hold = 1'b0; mem_rand = 1'b0; mem_fixed = 0; err_pct = 0;
      err_addr = 32'h0000_0001;
      model_reset();
      repeat (3) @(negedge clock);

      // reset values
      chk("rst_req", 32'(imemReq), 32'd0);
      chk("rst_addr", imemAddr, 32'h0);
      chk("rst_valid", 32'(idValid), 32'd0);
      checks++;
      assert (idSignals === '0) else begin
         errors++;
         $error("FAIL rst_sig observed %h expected 0", idSignals);
      end
      chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);

      // release with a stray ack during START: must be ignored
      nReset = 1'b1; imemAck = 1'b1; imemData = 32'hDEAD_BEEF;
      @(negedge clock);
      chk("start_req", 32'(imemReq), 32'd1);
      chk("start_addr", imemAddr, 32'h0);
      chk("start_valid", 32'(idValid), 32'd0);
      chk("wrap_req_addr", w_addr, 32'hFFFF_FFFC);

      // zero-wait streaming
      for (int i = 0; i < 4; i++) begin
         chk("stream_addr", imemAddr, 32'(i * 4));
         if (i > 0) chk("stream_valid", 32'(idValid), 32'd1);
         if (i == 1) begin
            chk("wrap_valid", 32'(w_valid), 32'd1);
            chk("wrap_pc", w_sig.programCounter, 32'hFFFF_FFFC);
            chk("wrap_link", w_sig.linkAddress, 32'h0);
            chk("wrap_addr2", w_addr, 32'h0);
         end
         tick(1'b0, 1'b0, 32'h0);
      end

      // decode stall for 3 cycles
      tick(1'b1, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 32'h0);
      chk("stall_req_drop", 32'(imemReq), 32'd0);
      chk("stall_hold", 32'(idValid), 32'd1);
      tick(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk("release_nogap", 32'(idValid), 32'd1);
         tick(1'b0, 1'b0, 32'h0);
      end

      // redirect while the request to 0x10 is outstanding
      mem_fixed = 2;
      tick(1'b0, 1'b1, 32'h0000_0008);
      n = 0;
      while (!(imemReq === 1'b1 && imemAddr === 32'h10 && !mem_busy) && n < 40) begin
         tick(1'b0, 1'b0, 32'h0);
         n++;
      end
      chk("find_req_10", 32'(n < 40), 32'd1);
      tick(1'b0, 1'b1, 32'h0000_1000);
      tick(1'b0, 1'b0, 32'h0);
      tick(1'b0, 1'b0, 32'h0);
      chk("redir_req", 32'(imemReq), 32'd1);
      chk("redir_addr", imemAddr, 32'h0000_1000);

      // bus fault at 0x20
      mem_fixed = 0;
      err_addr  = 32'h0000_0020;
      tick(1'b0, 1'b1, 32'h0000_0018);
      n = 0;
      while (!(idValid === 1'b1 && idSignals.exception === EXCEPT_FETCH_FAULT) && n < 20) begin
         tick(1'b0, 1'b0, 32'h0);
         n++;
      end
      chk("fault_valid", 32'(idValid), 32'd1);
      chk("fault_exc", 32'(idSignals.exception), 32'(EXCEPT_FETCH_FAULT));
      chk("fault_pc", idSignals.programCounter, 32'h20);
      chk("fault_instr", idSignals.instruction, 32'h0);
      err_addr = 32'h0000_0001;
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0);
      chk("fault_no_req", 32'(imemReq), 32'd0);
      tick(1'b0, 1'b1, 32'h0000_0100);
      chk("resume_req", 32'(imemReq), 32'd1);
      chk("resume_addr", imemAddr, 32'h0000_0100);

      // misaligned target
      tick(1'b0, 1'b1, 32'h0000_0102);
      chk("mis_valid", 32'(idValid), 32'd1);
      chk("mis_pc", idSignals.programCounter, 32'h0000_0102);
      chk("mis_exc", 32'(idSignals.exception), 32'(EXCEPT_MISALIGNED_FETCH));
      chk("mis_instr", idSignals.instruction, 32'h0);
      chk("mis_no_req", 32'(imemReq), 32'd0);
      tick(1'b1, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 32'h0);
      chk("mis_held", 32'(idValid), 32'd1);
      chk("mis_halted", 32'(imemReq), 32'd0);
      tick(1'b0, 1'b1, 32'h0000_0200);

      // randomized traffic
      mem_rand = 1'b1;
      err_pct  = 3;
      n = consumed;
      for (int i = 0; i < 1500; i++) begin
         logic st, rv;
         st  = ($urandom_range(0, 99) < 30);
         rv  = ($urandom_range(0, 99) < 3);
         tgt = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 6) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
         tick(st, rv, tgt);
      end
      chk("random_progress", 32'(consumed - n > 100), 32'd1);
      mem_rand = 1'b0;
      err_pct  = 0;

      // reset asserted mid-fetch
      mem_fixed = 3;
      tick(1'b0, 1'b1, 32'h0000_0300);
      n = 0;
      while (imemReq !== 1'b1 && n < 10) begin
         tick(1'b0, 1'b0, 32'h0);
         n++;
      end
      #2 nReset = 1'b0;
      #1;
      chk("mid_rst_req", 32'(imemReq), 32'd0);
      chk("mid_rst_addr", imemAddr, 32'h0);
      chk("mid_rst_valid", 32'(idValid), 32'd0);
      model_reset();
      mem_fixed = 0;
      @(negedge clock);
      imemAck = 1'b1; imemData = 32'h1234_5678; imemError = 1'b0;
      redirectValid = 1'b0; idStall = 1'b0;
      nReset = 1'b1;
      @(negedge clock);
      chk("rerun_req", 32'(imemReq), 32'd1);
      chk("rerun_addr", imemAddr, 32'h0);
      chk("rerun_valid", 32'(idValid), 32'd0);
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 32'h0);

      // drain: memory stops answering, everything fetched must be delivered
      mem_hold = 1'b1;
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 32'h0);
      chk("drain_queue", 32'(q.size()), 32'd0);
      chk("drain_valid", 32'(idValid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the five-stage pipeline. Produces the `IdSignals` bundle (instruction, programCounter, linkAddress, exception) and `idValid` consumed by the decode stage. Owns the program counter, issues single-outstanding requests to instruction memory, honours decode back-pressure through a one-entry skid buffer, and squashes in-flight fetches on branch/exception redirects from execute.

## Interface
- `RESET_VECTOR`, default `32'h00000000`: first fetch address after reset; must be word aligned.
- `clock` in 1: pipeline clock, all state on rising edge.
- `nReset` in 1: asynchronous, active-low reset.
- `imemReq` out 1: fetch request; held until `imemAck`.
- `imemAddr` out 32: word address of request; stable while `imemReq` && !`imemAck`.
- `imemAck` in 1: one-cycle response strobe; `imemData`/`imemError` valid with it.
- `imemData` in 32: fetched instruction word.
- `imemError` in 1: bus fault on this fetch.
- `redirectValid` in 1: one-cycle redirect pulse from execute (taken branch or exception entry).
- `redirectTarget` in 32: new PC, sampled with `redirectValid`.
- `idStall` in 1: decode cannot accept; hold output.
- `idValid` out 1: `idSignals` holds a live instruction.
- `idSignals` out `IdSignals`: to decode stage.

## Operation
- States: START (reset only), RUN, HALTED. Side flags: `skidFull`, `discard`, `pendingValid` + `pendingTarget`.
- START: one cycle after reset release; go to RUN, assert `imemReq`, `imemAddr` = `RESET_VECTOR`.
- RUN, ack with no error, not discarded: entry {instruction = `imemData`, programCounter = `imemAddr`, linkAddress = `imemAddr` + 4 (32-bit wrap, `FFFFFFFC` -> `00000000`), exception = `EXCEPT_NONE`}; `imemAddr` advances by 4, `imemReq` stays high.
- Ack with `imemError`: entry has exception = `EXCEPT_FETCH_FAULT`, instruction = 0; enter HALTED (`imemReq` = 0) until next redirect.
- Entry routing: output register if `idValid` = 0 or `idStall` = 0; else skid buffer. While `skidFull`, no new request issued. On `idStall` release, skid moves to output, `skidFull` clears, fetching resumes next cycle.
- Redirect (priority over everything): `idValid` and `skidFull` cleared next edge.
  - No request outstanding, or ack in same cycle: ack data dropped; next cycle `imemAddr` = target, `imemReq` = 1.
  - Request outstanding, no ack: `imemAddr` held (protocol stability); `discard` set, target saved in `pendingTarget`; returning ack dropped, target issued the cycle after. Later redirect before ack overwrites `pendingTarget`.
  - Target with bits [1:0] != 0: no memory request; output entry with exception = `EXCEPT_MISALIGNED_FETCH`, programCounter = target, instruction = 0, `idValid` = 1; enter HALTED.
- HALTED exits only on redirect; `idStall` still holds the fault entry.

## Timing
- Reset values: `imemReq` 0, `imemAddr` `RESET_VECTOR`, `idValid` 0, `idSignals` all zero with exception `EXCEPT_NONE`, state START, all flags 0.
- Ack at cycle N -> `idValid`/`idSignals` updated at edge ending N (visible N+1); next `imemAddr` visible N+1.
- Zero-wait memory (ack the cycle after request) sustains one instruction per cycle.
- Redirect at N with idle bus -> `imemReq` with target visible N+1; first target instruction earliest N+3.
- Simultaneous `idStall` release and ack with `skidFull`: skid goes to output, ack data goes to skid; no loss.
- Reset asserted mid-fetch: immediate return to reset values; late acks after release are ignored until START issues.

## Structure
- Shared package: `IdSignals`, `Exception` gains `EXCEPT_FETCH_FAULT` and `EXCEPT_MISALIGNED_FETCH`, and `WORD_BYTES = 4`.
- Sub-module `fetch_skid_buffer`: one-entry `IdSignals` holding register with full flag, load/unload/flush controls.

## Test plan
- Reset release, memory acks each cycle with `imemData` = address ^ `A5A5A5A5` -> `imemAddr` `0,4,8,C`; `idValid` continuous; linkAddress = PC + 4.
- `idStall` high 3 cycles during streaming -> output held, one entry in skid, `imemReq` drops; after release, entries arrive in order with no gap or duplicate.
- Redirect to `00001000` while request to `00000010` outstanding, ack 2 cycles later -> data for `10` never reaches `idValid`; next `imemAddr` = `1000`.
- Ack with `imemError` at `00000020` -> entry with `EXCEPT_FETCH_FAULT` and PC `20`; `imemReq` stays 0 until redirect to `00000100`, then resumes there.
- Redirect to `00000102` -> misaligned entry with PC `102`, no request issued, HALTED.
- `RESET_VECTOR` = `FFFFFFFC` -> linkAddress `00000000`, second fetch address `00000000`.
